// File: rtl/kf_host_loader.sv
// Host-side sequencer for kf_top: collects a parameter frame, bursts it behind START,
// waits for READY (masked, with timeout), then streams a window of result registers out.
module kf_host_loader #(
  parameter int W          = 24,
  parameter int ADDRW      = 5,
  parameter int N_LOAD     = 21,
  parameter int RD_BASE    = 0,
  parameter int N_OUT      = 6,
  parameter int READY_MASK = 12,
  parameter int TIMEOUT    = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  input  logic             out_ready,
  output logic             kf_start,
  output logic [W-1:0]     kf_data_in,
  output logic [ADDRW-1:0] kf_dir,
  input  logic             kf_ready,
  input  logic [W-1:0]     kf_data_out,
  output logic             busy,
  output logic             timeout_err
);

  localparam int PW = $clog2(N_LOAD + 1);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int KW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  typedef enum logic [1:0] {S_FILL, S_BURST, S_WAIT, S_READ} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    frame_buf [N_LOAD];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic [KW-1:0]   k;
  logic [1:0]      phase;
  logic            accept, last_in, burst_done, ready_ok, timed_out, out_hs, last_out;

  assign in_ready   = (state == S_FILL);
  assign busy       = (state != S_FILL);
  assign accept     = in_valid && in_ready;
  assign last_in    = accept && (wr_ptr == PW'(N_LOAD - 1));
  assign burst_done = (rd_ptr == PW'(N_LOAD));
  assign ready_ok   = kf_ready && (cnt >= CW'(READY_MASK));
  assign timed_out  = (cnt == CW'(TIMEOUT));
  assign out_hs     = out_valid && out_ready;
  assign last_out   = out_hs && (k == KW'(N_OUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL:  if (last_in) state_nxt = S_BURST;
      S_BURST: if (burst_done) state_nxt = S_WAIT;
      S_WAIT: begin
        if (ready_ok)       state_nxt = (N_OUT == 0) ? S_FILL : S_READ;
        else if (timed_out) state_nxt = S_FILL;
      end
      S_READ:  if (last_out) state_nxt = S_FILL;
      default: state_nxt = S_FILL;
    endcase
  end

  // Frame storage: contents are don't-care after reset, so no reset here
  always_ff @(posedge clk) begin
    if (accept) frame_buf[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      k           <= '0;
      phase       <= '0;
      kf_start    <= 1'b0;
      kf_data_in  <= '0;
      kf_dir      <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      timeout_err <= 1'b0;
    end else begin
      kf_start <= 1'b0;
      case (state)
        S_FILL: begin
          if (accept) begin
            wr_ptr      <= wr_ptr + PW'(1);
            timeout_err <= 1'b0;
          end
          // Word 0 goes out on the entry edge; a 1-word frame takes it straight from in_data
          if (last_in) begin
            wr_ptr     <= '0;
            rd_ptr     <= PW'(1);
            kf_start   <= 1'b1;
            kf_data_in <= (wr_ptr == '0) ? in_data : frame_buf[0];
          end
        end
        S_BURST: begin
          if (burst_done) begin
            kf_data_in <= '0;
            cnt        <= '0;
          end else begin
            kf_data_in <= frame_buf[rd_ptr];
            rd_ptr     <= rd_ptr + PW'(1);
          end
        end
        S_WAIT: begin
          cnt <= cnt + CW'(1);
          if (ready_ok) begin
            k      <= '0;
            phase  <= '0;
            kf_dir <= ADDRW'(RD_BASE);
          end else if (timed_out) begin
            timeout_err <= 1'b1;
          end
        end
        S_READ: begin
          // phase 0: address settles in the core, 1: capture, 2: hold until taken
          case (phase)
            2'd0: phase <= 2'd1;
            2'd1: begin
              out_data  <= kf_data_out;
              out_valid <= 1'b1;
              phase     <= 2'd2;
            end
            2'd2: begin
              if (out_hs) begin
                out_valid <= 1'b0;
                k         <= k + KW'(1);
                kf_dir    <= kf_dir + ADDRW'(1);
                phase     <= 2'd0;
              end
            end
            default: phase <= 2'd0;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kf_host_loader.sv
// Randomized bench for kf_host_loader: a small kf_top core model plus a frame/readback
// reference (expected burst = frame, expected results = core registers from the read window).
module tb_kf_host_loader;

  localparam int W          = 24;
  localparam int ADDRW      = 5;
  localparam int N_LOAD     = 6;
  localparam int RD_BASE    = 30;
  localparam int N_OUT      = 4;
  localparam int READY_MASK = 12;
  localparam int TIMEOUT    = 1023;

  logic             clk, rst;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]     in_data, out_data, kf_data_in, kf_data_out;
  logic             kf_start, kf_ready, busy, timeout_err;
  logic [ADDRW-1:0] kf_dir;

  kf_host_loader #(
    .W(W), .ADDRW(ADDRW), .N_LOAD(N_LOAD), .RD_BASE(RD_BASE), .N_OUT(N_OUT),
    .READY_MASK(READY_MASK), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .kf_start(kf_start), .kf_data_in(kf_data_in), .kf_dir(kf_dir), .kf_ready(kf_ready),
    .kf_data_out(kf_data_out), .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stimulus/reference state owned by the main process
  logic [W-1:0] frame_w [N_LOAD];
  logic [W-1:0] core_mem [32];
  int rdy_mode = 0, rdy_delay = 0, ordy_mode = 0, clr_tok = 0;

  // Monitor / core-model state owned by the negedge process
  int cyc = 0, seen_tok = 0, start_cycles = 0, burst_end_cyc = 0, first_vld_cyc = -1, vcnt = 0;
  bit cap_on = 0, burst_seen = 0, post_pending = 0, post_seen = 0;
  bit prev_valid = 0, prev_hs = 0, rst_prev = 0, hs;
  logic [W-1:0] post_val, hold_data;
  logic [ADDRW-1:0] hold_dir;
  logic [W-1:0] cap_q[$];
  logic [W-1:0] got_q[$];
  logic [ADDRW-1:0] dir_q[$];

  always @(negedge clk) begin
    cyc++;
    if (clr_tok != seen_tok) begin
      seen_tok = clr_tok;
      cap_q.delete(); got_q.delete(); dir_q.delete();
      cap_on = 0; burst_seen = 0; start_cycles = 0; post_pending = 0; post_seen = 0;
      first_vld_cyc = -1; vcnt = 0;
    end
    kf_data_out = core_mem[kf_dir];
    case (rdy_mode)
      1:       kf_ready = 1'b1;
      2:       kf_ready = burst_seen && ((cyc - burst_end_cyc) >= rdy_delay);
      default: kf_ready = 1'b0;
    endcase
    if (post_pending) begin
      post_val = kf_data_in; post_pending = 0; post_seen = 1;
    end
    if (kf_start) begin
      start_cycles++;
      if (!cap_on) begin cap_q.delete(); cap_on = 1; end
    end
    if (cap_on) begin
      cap_q.push_back(kf_data_in);
      if (cap_q.size() == N_LOAD) begin
        cap_on = 0; burst_seen = 1; burst_end_cyc = cyc; post_pending = 1;
      end
    end
    if (out_valid) vcnt++;
    case (ordy_mode)
      1:       out_ready = 1'($urandom_range(0, 1));
      2:       out_ready = (vcnt > 10);
      default: out_ready = 1'b1;
    endcase
    if (prev_valid && !prev_hs && !rst && !rst_prev) begin
      check_val("hold_vld", out_valid, 1);
      check_val("hold_data", out_data, hold_data);
      check_val("hold_dir", kf_dir, hold_dir);
    end
    hs = out_valid && out_ready;
    if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (hs) begin
      got_q.push_back(out_data); dir_q.push_back(kf_dir); vcnt = 0;
    end
    prev_valid = out_valid; prev_hs = hs; hold_data = out_data; hold_dir = kf_dir; rst_prev = rst;
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic mon_clear();
    clr_tok++;
    tick();
  endtask

  task automatic send_frame(input int vmode);
    int i = 0, guard = 0;
    bit clr_checked = 0;
    while (i < N_LOAD && guard < 200) begin
      tick(); guard++;
      if (i >= 1 && !clr_checked) begin
        check_val("terr_clr", timeout_err, 0);
        clr_checked = 1;
      end
      case (vmode)
        1:       in_valid = guard[0];
        2:       in_valid = 1'($urandom_range(0, 1));
        default: in_valid = 1'b1;
      endcase
      in_data = in_valid ? frame_w[i] : W'($urandom);
      if (in_valid && in_ready) i++;
    end
    check_val("fill_done", i, N_LOAD);
    tick();
    if (vmode != 0) begin
      for (int j = 0; j < 3; j++) begin
        in_valid = 1'b1; in_data = W'($urandom);
        check_val("no_consume", in_ready, 0);
        tick();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_burst();
    for (int g = 0; g < 100 && !burst_seen; g++) tick();
    check_val("burst_seen", burst_seen, 1);
    tick();
    for (int i = 0; i < N_LOAD && i < cap_q.size(); i++)
      check_val($sformatf("burst_w%0d", i), cap_q[i], frame_w[i]);
    check_val("start_1cyc", start_cycles, 1);
    check_val("post_zero", post_seen ? post_val : 24'hDEAD, 0);
  endtask

  task automatic run_txn(input int vmode, input int rmode, input int rdelay, input int omode,
                         input bit exp_out, input bit chk_mask);
    mon_clear();
    rdy_mode = rmode; rdy_delay = rdelay; ordy_mode = omode;
    send_frame(vmode);
    wait_burst();
    if (exp_out) begin
      for (int g = 0; g < 3000 && got_q.size() < N_OUT; g++) tick();
      check_val("n_out", got_q.size(), N_OUT);
      for (int k = 0; k < got_q.size(); k++) begin
        check_val($sformatf("rd_dir%0d", k), dir_q[k], (RD_BASE + k) % (1 << ADDRW));
        check_val($sformatf("rd_data%0d", k), got_q[k], core_mem[(RD_BASE + k) % (1 << ADDRW)]);
      end
      for (int g = 0; g < 20 && busy; g++) tick();
      check_val("idle_after", busy, 0);
      check_val("terr_ok", timeout_err, 0);
      if (chk_mask) begin
        check_val("mask_lo", first_vld_cyc >= burst_end_cyc + READY_MASK + 3, 1);
        check_val("mask_hi", first_vld_cyc <= burst_end_cyc + READY_MASK + 8, 1);
      end
    end else begin
      for (int g = 0; g < 1500 && busy; g++) tick();
      check_val("to_idle", busy, 0);
      check_val("to_lat", ((cyc - burst_end_cyc) >= TIMEOUT + 1) &&
                          ((cyc - burst_end_cyc) <= TIMEOUT + 2), 1);
      check_val("to_err", timeout_err, 1);
      check_val("to_nout", got_q.size(), 0);
      check_val("to_novld", first_vld_cyc, -1);
    end
  endtask

  task automatic rand_frame();
    for (int i = 0; i < N_LOAD; i++) frame_w[i] = W'($urandom);
    for (int a = 0; a < 32; a++) core_mem[a] = W'($urandom);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    for (int a = 0; a < 32; a++) core_mem[a] = '0;
    repeat (3) tick();
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_kf_start", kf_start, 0);
    check_val("rst_kf_data_in", kf_data_in, 0);
    check_val("rst_kf_dir", kf_dir, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_terr", timeout_err, 0);
    rst = 1'b0;
    tick();

    // 1D program frame, core raises READY 60 cycles after the burst
    frame_w[0] = 24'h004000; frame_w[1] = 24'h0000A4; frame_w[2] = 24'h000666;
    frame_w[3] = 24'h000000; frame_w[4] = 24'h004000; frame_w[5] = 24'h00A000;
    for (int a = 0; a < 32; a++) core_mem[a] = W'($urandom);
    core_mem[RD_BASE] = 24'h009199;
    run_txn(0, 2, 60, 0, 1, 0);

    // Gappy input and 10-cycle output back-pressure
    rand_frame(); run_txn(1, 2, 20, 2, 1, 0);
    // READY held high from the start: mask must be honoured
    rand_frame(); run_txn(0, 1, 0, 1, 1, 1);
    // READY never rises
    rand_frame(); run_txn(2, 0, 0, 0, 0, 0);
    // Next frame clears the sticky error
    rand_frame(); run_txn(0, 2, 30, 1, 1, 0);

    // Reset in the middle of a burst
    rand_frame(); mon_clear(); rdy_mode = 0;
    send_frame(0);
    for (int g = 0; g < 50 && cap_q.size() < 4; g++) tick();
    check_val("mid_burst_reached", cap_q.size() >= 4, 1);
    rst = 1'b1;
    tick();
    check_val("mrst_kf_start", kf_start, 0);
    check_val("mrst_kf_data_in", kf_data_in, 0);
    check_val("mrst_in_ready", in_ready, 1);
    check_val("mrst_busy", busy, 0);
    rst = 1'b0;
    rand_frame(); run_txn(0, 2, 15, 0, 1, 0);

    for (int t = 0; t < 4; t++) begin
      rand_frame();
      run_txn($urandom_range(0, 2), 2, $urandom_range(0, 40), $urandom_range(0, 2), 1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
